// File: rtl/fpu_pkg.sv
// Shared widths, status encoding, operand layout and FSM states for the
// custom 32-bit floating-point adder.
package fpu_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned EXP_W   = 6;
  localparam int unsigned FRAC_W  = 25;
  localparam int unsigned MAN_W   = FRAC_W + 1;  // hidden bit + fraction
  localparam int unsigned SUM_W   = MAN_W + 1;   // plus carry
  localparam int unsigned EXPC_W  = 8;           // signed exponent arithmetic
  localparam int unsigned LZC_W   = 5;
  localparam int unsigned STAT_W  = 4;

  localparam int unsigned BIAS    = 31;
  localparam int unsigned EXP_MAX = 63;
  localparam int unsigned ALIGN_ZERO = 27;       // shift distance that flushes the smaller operand

  localparam int unsigned ST_EXACT     = 0;
  localparam int unsigned ST_OVERFLOW  = 1;
  localparam int unsigned ST_UNDERFLOW = 2;
  localparam int unsigned ST_INEXACT   = 3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  function automatic logic [STAT_W-1:0] status_flag(input int unsigned idx);
    return STAT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter over the carry-extended mantissa sum.
module fpu_lzc
  import fpu_pkg::*;
(
  input  logic [SUM_W-1:0] value,
  output logic [LZC_W-1:0] count
);

  // Scan upward so the most significant set bit has the final word.
  always_comb begin
    count = LZC_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (value[i]) count = LZC_W'(SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu.sv
// Multi-cycle floating-point adder: IDLE -> ALIGN -> ADD -> NORM -> DONE,
// restarted only through reset, result and one-hot status held in DONE.
module fpu
  import fpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] op_A_in,
  input  logic [WORD_W-1:0] op_B_in,
  output logic [WORD_W-1:0] data_out,
  output logic [STAT_W-1:0] status_out
);

  localparam logic signed [EXPC_W-1:0] EXP_TOP = EXPC_W'(EXP_MAX);
  localparam logic signed [EXPC_W-1:0] EXP_LOW = EXPC_W'(1);

  state_t state_q, state_d;

  logic              sign_a, sign_b, res_sign;
  logic [EXPC_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0]  man_a, man_b;
  logic              flush_uf, sticky;
  logic [SUM_W-1:0]  sum;

  // Operand decode: exp 0 is zero, hidden bit otherwise, larger magnitude first.
  fp_t              in_a, in_b;
  logic [MAN_W-1:0] dec_man_a, dec_man_b;
  logic             dec_flush, b_larger;

  always_comb begin
    in_a      = fp_t'(op_A_in);
    in_b      = fp_t'(op_B_in);
    dec_man_a = (in_a.exp == '0) ? '0 : {1'b1, in_a.frac};
    dec_man_b = (in_b.exp == '0) ? '0 : {1'b1, in_b.frac};
    dec_flush = ((in_a.exp == '0) && (in_a.frac != '0)) ||
                ((in_b.exp == '0) && (in_b.frac != '0));
    b_larger  = {in_b.exp, dec_man_b} > {in_a.exp, dec_man_a};
  end

  // Alignment barrel shift with sticky collection.
  logic [EXPC_W-1:0] exp_diff;
  logic [MAN_W-1:0]  aligned_b;
  logic              align_lost;

  always_comb begin
    exp_diff   = exp_a - exp_b;
    aligned_b  = '0;
    align_lost = |man_b;
    if (exp_diff < EXPC_W'(ALIGN_ZERO)) begin
      aligned_b  = man_b >> exp_diff;
      align_lost = |(man_b & ~({MAN_W{1'b1}} << exp_diff));
    end
  end

  // Magnitude add/subtract; a cancelled difference is forced to +0.
  logic [SUM_W-1:0] add_sum;
  logic             add_sign;

  always_comb begin
    if (sign_a == sign_b) add_sum = {1'b0, man_a} + {1'b0, man_b};
    else                  add_sum = {1'b0, man_a} - {1'b0, man_b};
    add_sign = ((sign_a != sign_b) && (man_a == man_b)) ? 1'b0 : sign_a;
  end

  // Normalisation and exception classification.
  logic [LZC_W-1:0]         lz, norm_sh;
  logic [MAN_W-1:0]         norm_man;
  logic signed [EXPC_W-1:0] norm_exp;
  logic                     norm_sticky;
  logic [WORD_W-1:0]        res_data;
  logic [STAT_W-1:0]        res_status;

  fpu_lzc u_lzc (
    .value (sum),
    .count (lz)
  );

  always_comb begin
    norm_sh     = lz - LZC_W'(1);
    norm_man    = sum[MAN_W-1:0] << norm_sh;
    norm_exp    = exp_a - EXPC_W'(norm_sh);
    norm_sticky = sticky;
    if (sum[SUM_W-1]) begin
      norm_man    = sum[SUM_W-1:1];
      norm_exp    = exp_a + EXPC_W'(1);
      norm_sticky = sticky | sum[0];
    end

    res_data   = {res_sign, EXP_W'(norm_exp), norm_man[FRAC_W-1:0]};
    res_status = status_flag(ST_EXACT);
    if (sum == '0) begin
      res_data   = '0;
      res_status = flush_uf ? status_flag(ST_UNDERFLOW) : status_flag(ST_EXACT);
    end else if (norm_exp > EXP_TOP) begin
      res_data   = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      res_status = status_flag(ST_OVERFLOW);
    end else if (flush_uf || (norm_exp < EXP_LOW)) begin
      res_data   = '0;
      res_status = status_flag(ST_UNDERFLOW);
    end else if (norm_sticky) begin
      res_status = status_flag(ST_INEXACT);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: one stage per cycle, DONE holds until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers, each stage updated in its own state.
  always_ff @(posedge clock) begin
    if (reset) begin
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      res_sign   <= 1'b0;
      exp_a      <= '0;
      exp_b      <= '0;
      man_a      <= '0;
      man_b      <= '0;
      flush_uf   <= 1'b0;
      sticky     <= 1'b0;
      sum        <= '0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          flush_uf <= dec_flush;
          if (b_larger) begin
            sign_a <= in_b.sign;
            exp_a  <= EXPC_W'(in_b.exp);
            man_a  <= dec_man_b;
            sign_b <= in_a.sign;
            exp_b  <= EXPC_W'(in_a.exp);
            man_b  <= dec_man_a;
          end else begin
            sign_a <= in_a.sign;
            exp_a  <= EXPC_W'(in_a.exp);
            man_a  <= dec_man_a;
            sign_b <= in_b.sign;
            exp_b  <= EXPC_W'(in_b.exp);
            man_b  <= dec_man_b;
          end
        end
        ALIGN: begin
          man_b  <= aligned_b;
          sticky <= align_lost;
        end
        ADD: begin
          sum      <= add_sum;
          res_sign <= add_sign;
        end
        NORM: begin
          data_out   <= res_data;
          status_out <= res_status;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu.sv
// Self-checking bench for fpu: directed cases, randomized operands against a
// value-level reference model, mid-operation reset and output hold.
module tb_fpu;

  localparam logic [3:0] S_EXACT = 4'b0001;
  localparam logic [3:0] S_OVF   = 4'b0010;
  localparam logic [3:0] S_UNF   = 4'b0100;
  localparam logic [3:0] S_INEX  = 4'b1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_A_in = '0;
  logic [31:0] op_B_in = '0;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int checks = 0;
  int passes = 0;

  fpu dut (
    .clock      (clock),
    .reset      (reset),
    .op_A_in    (op_A_in),
    .op_B_in    (op_B_in),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clock = ~clock;

  // Reference: exact integer mantissas, alignment by division, loop normalisation.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint ea, eb, ma, mb, al, r, e, d, t;
    bit sa, sb, flush, st, sgn;
    logic [31:0] res;
    logic [3:0]  stat;
    sa = a[31]; ea = longint'(a[30:25]);
    sb = b[31]; eb = longint'(b[30:25]);
    ma = (ea == 0) ? 0 : (longint'(1) << 25) + longint'(a[24:0]);
    mb = (eb == 0) ? 0 : (longint'(1) << 25) + longint'(b[24:0]);
    flush = (ea == 0 && a[24:0] != 0) || (eb == 0 && b[24:0] != 0);
    if (eb * (longint'(1) << 26) + mb > ea * (longint'(1) << 26) + ma) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
      sgn = sa; sa = sb; sb = sgn;
    end
    d = ea - eb;
    if (d >= 27) begin
      al = 0; st = (mb != 0);
    end else begin
      al = mb / (longint'(1) << d);
      st = (mb % (longint'(1) << d)) != 0;
    end
    r = (sa == sb) ? ma + al : ma - al;
    sgn = sa;
    if (r == 0) return {32'h0, flush ? S_UNF : S_EXACT};
    e = ea;
    while (r >= (longint'(1) << 26)) begin
      if (r % 2 != 0) st = 1'b1;
      r = r / 2;
      e = e + 1;
    end
    while (r < (longint'(1) << 25)) begin
      r = r * 2;
      e = e - 1;
    end
    if (e > 63) begin
      res = {sgn, 6'h3F, 25'h0}; stat = S_OVF;
    end else if (flush || e < 1) begin
      res = 32'h0; stat = S_UNF;
    end else begin
      res = {sgn, 6'(e), 25'(r)};
      stat = st ? S_INEX : S_EXACT;
    end
    return {res, stat};
  endfunction

  // Restart through reset, run 4 edges; early = outputs after 3 edges.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        output logic [35:0] early, output logic [35:0] fin);
    @(negedge clock); reset = 1'b1; op_A_in = a; op_B_in = b;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    if (scramble) begin
      op_A_in = $urandom; op_B_in = $urandom;
    end
    repeat (2) @(posedge clock);
    #1 early = {data_out, status_out};
    @(posedge clock);
    #1 fin = {data_out, status_out};
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 1'b1; op_A_in = 32'h3E000000; op_B_in = 32'h3E000000;
    @(posedge clock); #1;
    checks++;
    if ({data_out, status_out} !== 36'h0)
      $display("FAIL reset_state: got %h/%b expected 00000000/0000", data_out, status_out);
    else passes++;
  endtask

  task automatic test_directed();
    logic [31:0] ta [9] = '{32'hBE000000, 32'h40000000, 32'h3E000000, 32'h3E000000, 32'h3F000000,
                            32'h3F000000, 32'h7F000000, 32'h00000002, 32'h3E000000};
    logic [31:0] tb [9] = '{32'hBE000000, 32'hC2000000, 32'hBE000000, 32'h00000000, 32'h3C000000,
                            32'h40400000, 32'h7F000000, 32'h80000000, 32'h02000000};
    logic [31:0] td [9] = '{32'hC0000000, 32'hC0000000, 32'h00000000, 32'h3E000000, 32'h40000000,
                            32'h41C00000, 32'h7E000000, 32'h00000000, 32'h3E000000};
    logic [3:0]  ts [9] = '{S_EXACT, S_EXACT, S_EXACT, S_EXACT, S_EXACT,
                            S_EXACT, S_OVF, S_UNF, S_INEX};
    logic [35:0] early, fin;
    for (int i = 0; i < 9; i++) begin
      run_op(ta[i], tb[i], 1'b0, early, fin);
      checks++;
      if (early !== 36'h0)
        $display("FAIL directed%0d_latency: got %h expected 000000000 after 3 edges", i, early);
      else passes++;
      checks++;
      if (fin !== {td[i], ts[i]})
        $display("FAIL directed%0d %h+%h: got %h/%b expected %h/%b",
                 i, ta[i], tb[i], fin[35:4], fin[3:0], td[i], ts[i]);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [35:0] early, fin, exp_v;
    int unsigned mode, ea, eb;
    for (int i = 0; i < 80; i++) begin
      mode = $urandom_range(0, 3);
      a = $urandom; b = $urandom;
      ea = $urandom_range(1, 63);
      case (mode)
        1: begin
          eb = ea + $urandom_range(0, 4);
          eb = (eb < 3) ? 1 : ((eb - 2 > 63) ? 63 : eb - 2);
          a[30:25] = 6'(ea); b[30:25] = 6'(eb);
        end
        2: begin
          a[30:25] = 6'(ea); b[30:25] = 6'h0;
          if ($urandom_range(0, 1) == 0) b[24:0] = '0;
        end
        3: begin
          a[30:25] = 6'($urandom_range(60, 63));
          b = {~a[31], a[30:0]};
          if ($urandom_range(0, 1) == 0) b[31] = a[31];
        end
        default: ;
      endcase
      exp_v = ref_add(a, b);
      run_op(a, b, 1'b1, early, fin);
      checks++;
      if (early !== 36'h0)
        $display("FAIL random%0d_latency: got %h expected 000000000 after 3 edges", i, early);
      else passes++;
      checks++;
      if (fin !== exp_v)
        $display("FAIL random%0d %h+%h: got %h/%b expected %h/%b",
                 i, a, b, fin[35:4], fin[3:0], exp_v[35:4], exp_v[3:0]);
      else passes++;
    end
  endtask

  task automatic test_midop_reset();
    logic [35:0] early, fin;
    run_op(32'h3F000000, 32'h3C000000, 1'b0, early, fin);
    @(negedge clock); reset = 1'b1; op_A_in = 32'h3F000000; op_B_in = 32'h40400000;
    @(negedge clock); reset = 1'b0;
    @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({data_out, status_out} !== 36'h0)
      $display("FAIL midop_reset_clear: got %h/%b expected 00000000/0000", data_out, status_out);
    else passes++;
    @(negedge clock); reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({data_out, status_out} !== 36'h0)
      $display("FAIL midop_reset_early: got %h/%b expected 00000000/0000", data_out, status_out);
    else passes++;
    @(posedge clock); #1;
    checks++;
    if ({data_out, status_out} !== {32'h41C00000, S_EXACT})
      $display("FAIL midop_reset_restart: got %h/%b expected 41c00000/0001", data_out, status_out);
    else passes++;
  endtask

  task automatic test_hold();
    logic [35:0] early, fin;
    run_op(32'h40000000, 32'hC2000000, 1'b0, early, fin);
    op_A_in = 32'h7F000000; op_B_in = 32'h7F000000;
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if ({data_out, status_out} !== {32'hC0000000, S_EXACT})
      $display("FAIL done_hold: got %h/%b expected c0000000/0001", data_out, status_out);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_midop_reset();
    test_hold();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
